uart_loader: RTL and testbench
==============================

# uart_loader

UART boot loader that acts as a bus initiator into the mmio address space. It receives a framed program image over the board UART pin, assembles little-endian 32-bit words and issues word stores into BRAM while holding the CPU in reset. On completion it releases the CPU. It sits beside the core and shares the mmio store port via an external mux that selects the loader while `cpu_hold` is high.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200).
- `LOAD_BASE`, 32'h0: byte address of the first stored word.
- `MAX_WORDS`, 32'hC800: largest accepted image, in words (BRAM span 0x32000 bytes).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `STORE_STATE`, 3'd3: value driven on `bus_state` during a store, matching the core's memory-stage state code.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `uart_txd_in` in 1: serial input from the host, 8N1, idle high.
- `cpu_hold` out 1: holds the core in reset and selects the loader on the bus.
- `done` out 1: image fully written.
- `err` out 1: sticky error flag, either a framing error or an oversize length.
- `bus_store_enable` out 1: one-cycle store strobe.
- `bus_is_sw` out 1: word-store qualifier, equal to `bus_store_enable`.
- `bus_state` out 3: `STORE_STATE` while `bus_store_enable` is high, otherwise 0.
- `bus_address` out 32: byte address of the store, word-aligned.
- `bus_data` out 32: store data.

## Operation
- UART receiver:
  - 2-flop synchronizer on `uart_txd_in`.
  - Start is a falling edge in idle. It is re-checked low at half a bit time; if high, it is discarded as a glitch.
  - 8 data bits are sampled at the centres of their bit periods, LSB first.
  - The stop bit is sampled at its centre:
    - High: a byte pulse is emitted for one cycle.
    - Low: framing error. `err` is set, the byte is dropped, and the loader FSM returns to `SYNC`.
- Loader FSM states, all transitions on byte pulses unless stated:
  - `SYNC`: if the byte equals `SYNC_BYTE`, go to `LEN` and clear the byte counter; otherwise stay.
  - `LEN`: collect 4 bytes, little-endian, into `words_left`. After the 4th byte:
    - 0 → `DONE`.
    - Greater than `MAX_WORDS` → set `err`, go to `SYNC`.
    - Otherwise `bus_address` ← `LOAD_BASE`, go to `DATA`.
  - `DATA`: collect 4 bytes little-endian into `bus_data`. After the 4th byte, go to `WRITE`.
  - `WRITE`: exactly one cycle. Assert the store strobes. On the next edge, `bus_address` += 4 and `words_left` -= 1. If the new count is 0 → `DONE`, else → `DATA`.
  - `DONE`: terminal. `done`=1, `cpu_hold`=0. Further UART input is ignored until `rst`.
- Arithmetic:
  - `bus_address` wraps modulo 2^32; a length check ≤ `MAX_WORDS` with the default base keeps it inside BRAM.
  - `words_left` is 32 bits.
- `err` is sticky until `rst` and does not block a later valid frame.

## Timing
- Reset values:
  - `cpu_hold`=1, `done`=0, `err`=0.
  - `bus_store_enable`=0, `bus_is_sw`=0, `bus_state`=0.
  - `bus_address`=`LOAD_BASE`, `bus_data`=0.
  - FSM in `SYNC`, receiver idle.
- Byte pulse timing: fires 2 (synchronizer) + 9.5·`CLKS_PER_BIT` cycles (±1) after the start-bit falling edge at the pin.
- Store latency: `bus_store_enable` rises on the cycle after the 4th data byte pulse. It is high for exactly 1 cycle, with `bus_address` and `bus_data` stable during that cycle.
- No ready/backpressure: the responder accepts a store in one cycle. Bytes arrive ≥10·`CLKS_PER_BIT` apart, so WRITE never collides with a byte pulse.
- `done` and the `cpu_hold` release occur on the same edge:
  - the edge after the last store cycle, or
  - the edge after the 4th length byte when the length is 0.
- A byte pulse arriving in `DONE` has no effect.
- `rst` mid-frame: all state returns to reset values on the next edge; a partial byte in flight is discarded.

## Structure
- Shared package `loader_pkg`: FSM state enum (`SYNC`, `LEN`, `DATA`, `WRITE`, `DONE`), `SYNC_BYTE` default, `STORE_STATE` code (shared with the core's state encoding), BRAM span constant 0x32000.
- Sub-module `uart_rx` (parameter `CLKS_PER_BIT`):
  - Inputs: `clk`, `rst`, serial input.
  - Outputs: `rx_byte[7:0]`, `rx_valid` pulse, `rx_frame_err` pulse.
- The loader FSM is in the top module.

## Test plan
- Reset then idle line for 20 bit times → `cpu_hold`=1, `done`=0, no store strobes.
- Frame A5, 02 00 00 00, 78 56 34 12, EF BE AD DE → two 1-cycle stores: (0x0, 0x12345678) then (0x4, 0xDEADBEEF). `done`=1 and `cpu_hold`=0 on the edge after the second store.
- Bytes 00 FF then A5, 01 00 00 00, 01 00 00 00 → leading bytes ignored; one store (0x0, 0x00000001).
- Frame A5, 00 00 00 00 → `done`=1 with no store issued.
- A5, 01 C8 00 00 (0xC801 words) → `err`=1, FSM back in `SYNC`. A subsequent valid 1-word frame is still stored and completes.
- Byte with low stop bit mid-data → `err`=1, no store. Assert `rst` mid-byte → all outputs return to reset values.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART boot loader.
//   loader_state_t    : loader FSM state encoding
//   SYNC_BYTE_DEFAULT : default frame start marker
//   STORE_STATE_CODE  : core memory-stage state code driven during a store
//   BRAM_SPAN_BYTES   : size of the program BRAM in bytes
//   MAX_WORDS_DEFAULT : largest image that fits in BRAM, in 32-bit words
package loader_pkg;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [2:0]  STORE_STATE_CODE  = 3'd3;
    localparam logic [31:0] BRAM_SPAN_BYTES   = 32'h0003_2000;
    localparam logic [31:0] MAX_WORDS_DEFAULT = BRAM_SPAN_BYTES >> 2;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-bit glitch rejection.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   rx_in        : asynchronous serial input, idle high
//   rx_byte      : last assembled byte, valid while rx_valid is high
//   rx_valid     : one-cycle pulse, byte received with a good stop bit
//   rx_frame_err : one-cycle pulse, stop bit sampled low (byte dropped)
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          valid_n, ferr_n;

    // Synchronizer resets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            state        <= RX_IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta      <= rx_in;
            rx_sync      <= rx_meta;
            rx_prev      <= rx_sync;
            state        <= state_n;
            timer        <= timer_n;
            bit_idx      <= bit_idx_n;
            shift        <= shift_n;
            rx_valid     <= valid_n;
            rx_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;

        if (state != RX_IDLE && timer != '0) begin
            timer_n = timer - 1'b1;
        end else begin
            unique case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state_n = RX_START;
                        timer_n = HALF_BIT;
                    end
                end
                RX_START: begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (!rx_sync) begin
                        state_n   = RX_BITS;
                        timer_n   = FULL_BIT;
                        bit_idx_n = '0;
                    end else begin
                        state_n = RX_IDLE;
                    end
                end
                RX_BITS: begin
                    shift_n = {rx_sync, shift[7:1]};
                    timer_n = FULL_BIT;
                    if (bit_idx == 3'd7) begin
                        state_n = RX_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
                RX_STOP: begin
                    state_n = RX_IDLE;
                    if (rx_sync) valid_n = 1'b1;
                    else         ferr_n  = 1'b1;
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

    assign rx_byte = shift;

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: receives a framed image and writes it word by word into
// BRAM through the shared mmio store port, holding the CPU until complete.
//   clk, rst         : system clock, synchronous active-high reset
//   uart_txd_in      : serial input from the host
//   cpu_hold         : keeps the core in reset / selects loader on the bus
//   done             : image fully written
//   err              : sticky framing / oversize error
//   bus_store_enable : one-cycle store strobe
//   bus_is_sw        : word-store qualifier (same as bus_store_enable)
//   bus_state        : STORE_STATE during a store, else 0
//   bus_address      : word-aligned store byte address
//   bus_data         : store data
//
// state | meaning
// SYNC  | waiting for the start marker
// LEN   | collecting the 4-byte little-endian word count
// DATA  | collecting the 4 bytes of the next word
// WRITE | single store cycle on the bus
// DONE  | image loaded, CPU released, UART ignored
module uart_loader
    import loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] LOAD_BASE    = 32'h0,
    parameter logic [31:0] MAX_WORDS    = MAX_WORDS_DEFAULT,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter logic [2:0]  STORE_STATE  = STORE_STATE_CODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_txd_in,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic        bus_store_enable,
    output logic        bus_is_sw,
    output logic [2:0]  bus_state,
    output logic [31:0] bus_address,
    output logic [31:0] bus_data
);

    logic [7:0]    rx_byte;
    logic          rx_valid, rx_frame_err;

    loader_state_t state, state_n;
    logic [1:0]    byte_cnt, byte_cnt_n;
    logic [31:0]   words_left, words_left_n;
    logic [31:0]   address_n, data_n;
    logic          err_n;
    logic [31:0]   len_full, words_dec;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (uart_txd_in),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            byte_cnt    <= '0;
            words_left  <= '0;
            bus_address <= LOAD_BASE;
            bus_data    <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            byte_cnt    <= byte_cnt_n;
            words_left  <= words_left_n;
            bus_address <= address_n;
            bus_data    <= data_n;
            err         <= err_n;
        end
    end

    // Bytes shift in from the top so the first byte lands in bits [7:0].
    assign len_full  = {rx_byte, words_left[31:8]};
    assign words_dec = words_left - 32'd1;

    always_comb begin
        state_n      = state;
        byte_cnt_n   = byte_cnt;
        words_left_n = words_left;
        address_n    = bus_address;
        data_n       = bus_data;
        err_n        = err;

        unique case (state)
            SYNC: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_n    = LEN;
                    byte_cnt_n = '0;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    words_left_n = len_full;
                    byte_cnt_n   = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (len_full == '0) begin
                            state_n = DONE;
                        end else if (len_full > MAX_WORDS) begin
                            err_n   = 1'b1;
                            state_n = SYNC;
                        end else begin
                            address_n = LOAD_BASE;
                            state_n   = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    data_n     = {rx_byte, bus_data[31:8]};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) state_n = WRITE;
                end
            end
            WRITE: begin
                address_n    = bus_address + 32'd4;
                words_left_n = words_dec;
                byte_cnt_n   = '0;
                state_n      = (words_dec == '0) ? DONE : DATA;
            end
            DONE: ;
            default: state_n = SYNC;
        endcase

        // A bad stop bit abandons the frame; the store cycle and the terminal
        // state are never interrupted.
        if (rx_frame_err && state != DONE && state != WRITE) begin
            err_n   = 1'b1;
            state_n = SYNC;
        end
    end

    assign bus_store_enable = (state == WRITE);
    assign bus_is_sw        = bus_store_enable;
    assign bus_state        = bus_store_enable ? STORE_STATE : 3'd0;
    assign done             = (state == DONE);
    assign cpu_hold         = !done;

endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;

    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] MAXW = 32'h0000_C800;
    localparam logic [2:0]  SST  = 3'd3;
    // Store / zero-length done visible 2 + 9.5 bit times (+-1) plus one cycle after start edge.
    localparam int unsigned WIN_LO = 2 + (CPB * 19) / 2;
    localparam int unsigned WIN_HI = 4 + (CPB * 19) / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_txd_in = 1'b1;
    logic        cpu_hold, done, err;
    logic        bus_store_enable, bus_is_sw;
    logic [2:0]  bus_state;
    logic [31:0] bus_address, bus_data;

    uart_loader #(
        .CLKS_PER_BIT(CPB),
        .LOAD_BASE   (BASE),
        .MAX_WORDS   (MAXW),
        .SYNC_BYTE   (8'hA5),
        .STORE_STATE (SST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_txd_in     (uart_txd_in),
        .cpu_hold        (cpu_hold),
        .done            (done),
        .err             (err),
        .bus_store_enable(bus_store_enable),
        .bus_is_sw       (bus_is_sw),
        .bus_state       (bus_state),
        .bus_address     (bus_address),
        .bus_data        (bus_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         bad;
    } rx_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    st_t         exp_q[$];
    rx_t         stim[$];
    bit          exp_done, exp_err, exp_zero_len;
    int          tests = 0;
    int          fails = 0;
    int          n_stores = 0;
    int unsigned cyc = 0;
    int unsigned last_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-stream interpretation of the frame format: what stores must appear
    // and where done/err must end up after the whole stream.
    function automatic void model_run(input rx_t s[$]);
        int          i;
        logic [31:0] len, word;
        bit          ok;
        i = 0;
        while (i < s.size() && !exp_done) begin
            if (s[i].bad) begin exp_err = 1; i++; continue; end
            if (s[i].d != 8'hA5) begin i++; continue; end
            i++;
            len = 0;
            ok  = 1;
            for (int k = 0; k < 4; k++) begin
                if (i >= s.size()) return;
                if (s[i].bad) begin exp_err = 1; ok = 0; i++; break; end
                len |= 32'(s[i].d) << (8 * k);
                i++;
            end
            if (!ok) continue;
            if (len == 0) begin exp_done = 1; exp_zero_len = 1; return; end
            if (len > MAXW) begin exp_err = 1; continue; end
            for (longint w = 0; w < longint'(len) && ok; w++) begin
                word = 0;
                for (int k = 0; k < 4; k++) begin
                    if (i >= s.size()) return;
                    if (s[i].bad) begin exp_err = 1; ok = 0; i++; break; end
                    word |= 32'(s[i].d) << (8 * k);
                    i++;
                end
                if (ok) exp_q.push_back('{addr: BASE + 32'(w) * 32'd4, data: word});
            end
            if (ok) exp_done = 1;
        end
    endfunction

    function automatic void add(input logic [7:0] d, input bit bad = 0);
        stim.push_back('{d: d, bad: bad});
    endfunction

    task automatic hold_bit(input logic v);
        uart_txd_in = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input rx_t b);
        @(posedge clk);
        #1;
        last_start = cyc;
        hold_bit(1'b0);
        for (int k = 0; k < 8; k++) hold_bit(b.d[k]);
        hold_bit(b.bad ? 1'b0 : 1'b1);
        hold_bit(1'b1);
        hold_bit(1'b1);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_byte(stim[k]);
    endtask

    task automatic clear_model();
        exp_q.delete();
        stim.delete();
        exp_done     = 0;
        exp_err      = 0;
        exp_zero_len = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        uart_txd_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic end_check(input string tag);
        repeat (2 * CPB) @(posedge clk);
        #1;
        chk({tag, "_pending_stores"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Per-cycle comparison of the bus and status outputs against the model.
    initial begin
        bit          prev_store = 0;
        bit          prev_done  = 0;
        int unsigned dt;
        st_t         e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("is_sw_eq_store", 32'(bus_is_sw), 32'(bus_store_enable));
                chk("bus_state", 32'(bus_state), bus_store_enable ? 32'(SST) : 32'd0);
                chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
                if (bus_store_enable) begin
                    n_stores++;
                    dt = cyc - last_start;
                    chk("store_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("store_addr", bus_address, e.addr);
                        chk("store_data", bus_data, e.data);
                        chk("store_timing", 32'(dt >= WIN_LO && dt <= WIN_HI), 32'd1);
                    end
                    chk("done_low_during_store", 32'(done), 32'd0);
                end
                if (done && !prev_done) begin
                    dt = cyc - last_start;
                    chk("done_expected", 32'(exp_done), 32'd1);
                    if (exp_zero_len)
                        chk("done_timing_zero_len", 32'(dt >= WIN_LO && dt <= WIN_HI), 32'd1);
                    else
                        chk("done_after_store", 32'(prev_store), 32'd1);
                end
            end
            prev_store = bus_store_enable && !rst;
            prev_done  = done;
        end
    end

    initial begin
        clear_model();
        // Reset and an idle line.
        do_reset();
        repeat (20 * CPB) @(posedge clk);
        #1;
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", bus_address, BASE);
        chk("rst_data", bus_data, 32'd0);
        chk("idle_no_stores", 32'(n_stores), 32'd0);

        // Two-word image, then a byte after completion which must be ignored.
        do_reset();
        add(8'hA5); add(8'h02); add(8'h00); add(8'h00); add(8'h00);
        add(8'h78); add(8'h56); add(8'h34); add(8'h12);
        add(8'hEF); add(8'hBE); add(8'hAD); add(8'hDE);
        model_run(stim);
        chk("modelA_count", 32'(exp_q.size()), 32'd2);
        chk("modelA_w0", exp_q[0].data, 32'h1234_5678);
        chk("modelA_a1", exp_q[1].addr, 32'h4);
        chk("modelA_w1", exp_q[1].data, 32'hDEAD_BEEF);
        send_range(0, 12);
        end_check("two_words");
        chk("A_done_literal", 32'(done), 32'd1);
        send_byte('{d: 8'hA5, bad: 0});
        end_check("after_done");
        chk("A_store_total", 32'(n_stores), 32'd2);

        // Leading junk bytes before the marker.
        do_reset();
        add(8'h00); add(8'hFF);
        add(8'hA5); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
        add(8'h01); add(8'h00); add(8'h00); add(8'h00);
        model_run(stim);
        chk("modelB_w0", exp_q[0].data, 32'h0000_0001);
        send_range(0, stim.size() - 1);
        end_check("leading_junk");

        // Zero-length image.
        do_reset();
        add(8'hA5); add(8'h00); add(8'h00); add(8'h00); add(8'h00);
        model_run(stim);
        chk("modelC_done_no_store", 32'(exp_done && exp_q.size() == 0), 32'd1);
        send_range(0, 4);
        end_check("zero_len");
        chk("zero_len_total", 32'(n_stores), 32'd3);

        // Oversize length, then a valid one-word frame.
        do_reset();
        add(8'hA5); add(8'h01); add(8'hC8); add(8'h00); add(8'h00);
        add(8'hA5); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
        add(8'hDD); add(8'hCC); add(8'hBB); add(8'hAA);
        model_run(stim);
        chk("modelD_err", 32'(exp_err), 32'd1);
        chk("modelD_w0", exp_q[0].data, 32'hAABB_CCDD);
        send_range(0, 4);
        repeat (CPB) @(posedge clk);
        #1;
        chk("oversize_err", 32'(err), 32'd1);
        chk("oversize_hold", 32'(cpu_hold), 32'd1);
        send_range(5, stim.size() - 1);
        end_check("after_oversize");

        // Framing error inside the data, then a valid frame.
        do_reset();
        add(8'hA5); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
        add(8'h11); add(8'h22); add(8'h33, 1);
        add(8'hA5); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
        add(8'h44); add(8'h33); add(8'h22); add(8'h11);
        model_run(stim);
        send_range(0, 7);
        repeat (CPB) @(posedge clk);
        #1;
        chk("ferr_err", 32'(err), 32'd1);
        chk("ferr_no_done", 32'(done), 32'd0);
        send_range(8, stim.size() - 1);
        end_check("after_ferr");

        // Reset in the middle of a byte.
        do_reset();
        add(8'h00, 1);
        add(8'hA5); add(8'h02); add(8'h00); add(8'h00); add(8'h00);
        add(8'h5A);
        model_run(stim);
        send_range(0, stim.size() - 1);
        chk("pre_rst_err", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        uart_txd_in = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_store", 32'(bus_store_enable), 32'd0);
        chk("midrst_is_sw", 32'(bus_is_sw), 32'd0);
        chk("midrst_state", 32'(bus_state), 32'd0);
        chk("midrst_addr", bus_address, BASE);
        chk("midrst_data", bus_data, 32'd0);
        uart_txd_in = 1'b1;
        rst = 1'b0;
        clear_model();
        repeat (12 * CPB) @(posedge clk);
        add(8'hA5); add(8'h00); add(8'h00); add(8'h00); add(8'h00);
        model_run(stim);
        send_range(0, 4);
        end_check("after_midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
